alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_multicycle: multi-cycle ALU started by the rising edge of en_group;  |
// | optional flags via ALU_MULTICYCLE_FLAGS_EN.   Revision: 1.0             |
// +--------------------------------------------------------------------------+
module alu_multicycle #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_group,
  input  logic [2:0]       alu_func,
  input  logic             alu_in_sel,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] imm,
  output logic             alu_end,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);
  localparam logic [2:0] F_MOVE   = 3'b000;
  localparam logic [2:0] F_ADD    = 3'b001;
  localparam logic [2:0] F_SUB    = 3'b010;
  localparam logic [2:0] F_AND    = 3'b011;
  localparam logic [2:0] F_OR     = 3'b100;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               en_dly_q, en_dly_d;
  logic               arm_q, arm_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         func_q, func_d;
  logic               alu_end_q, alu_end_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic [WIDTH-1:0]   res_w;
  logic               start_w;
  logic               done_entry_w;

  // arm_q keeps a level already high at reset release from counting as a start
  assign start_w      = en_group & ~en_dly_q & arm_q;
  assign done_entry_w = (state_q == S_BUSY) && (cnt_q == CNT_LAST);

  always_comb begin : p_result
    res_w = '0;
    case (func_q)
      F_MOVE:  res_w = b_q;
      F_ADD:   res_w = a_q + b_q;
      F_SUB:   res_w = a_q - b_q;
      F_AND:   res_w = a_q & b_q;
      F_OR:    res_w = a_q | b_q;
      default: res_w = '0;
    endcase
  end

  always_comb begin : p_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    en_dly_d  = en_group;
    arm_d     = arm_q | ~en_group;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    alu_end_d = 1'b0;
    alu_out_d = alu_out_q;
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          a_d     = rd_data;
          b_d     = alu_in_sel ? imm : rs_data;
          func_d  = alu_func;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (done_entry_w) begin
          state_d   = S_DONE;
          alu_end_d = 1'b1;
          alu_out_d = res_w;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      en_dly_q  <= 1'b0;
      arm_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      alu_end_q <= 1'b0;
      alu_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_dly_q  <= en_dly_d;
      arm_q     <= arm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      alu_end_q <= alu_end_d;
      alu_out_q <= alu_out_d;
    end
  end

  assign alu_end = alu_end_q;
  assign alu_out = alu_out_q;

`ifdef ALU_MULTICYCLE_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;
  logic carry_w;

  // add wrapped iff the truncated sum is below an operand; sub borrows iff A < B
  always_comb begin : p_flags
    carry_w = 1'b0;
    case (func_q)
      F_ADD:   carry_w = (res_w < a_q);
      F_SUB:   carry_w = (a_q < b_q);
      default: carry_w = 1'b0;
    endcase
    flag_z_d = done_entry_w ? (res_w == '0) : flag_z_q;
    flag_c_d = done_entry_w ? carry_w       : flag_c_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule
`default_nettype wire
